sid_bus_master: RTL

SID_BUS_MASTER -- requirements
Module: sid_bus_master

---
 rtl/sid_bus_master.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/sid_bus_master.sv
// Command-queued register bus master for a SID: buffers read/write commands,
// paces each one by a delay counted in clkEn ticks, then issues a one-cycle access.
module sid_bus_master #(
  parameter int DEPTH   = 8,
  parameter int DELAY_W = 16
) (
  input  logic               clk,
  input  logic               iRstN,
  input  logic               clkEn,
  input  logic               iValid,
  output logic               oReady,
  input  logic               iRead,
  input  logic [DELAY_W-1:0] iDelay,
  input  logic [4:0]         iAddr,
  input  logic [7:0]         iData,
  input  logic               iFlush,
  output logic               oWE,
  output logic [4:0]         oAddr,
  output logic [7:0]         oDataW,
  input  logic [7:0]         iDataR,
  output logic               oRdValid,
  output logic [7:0]         oRdData,
  output logic               oBusy
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 1 + DELAY_W + 5 + 8;
  localparam logic [AW:0] C_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [EW-1:0]        r_mem [DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic                 r_cmd_read;
  logic [4:0]           r_cmd_addr;
  logic [7:0]           r_cmd_data;
  logic [DELAY_W-1:0]   r_cnt;
  logic                 r_we;
  logic [4:0]           r_addr;
  logic [7:0]           r_data_w;
  logic                 r_rd_valid;
  logic [7:0]           r_rd_data;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_issue;
  logic                 w_cnt_dec;
  logic [EW-1:0]        w_head;

  // Ready comes from the registered count only, so a pop in the same cycle never widens it.
  assign oReady   = (r_count != C_FULL);
  assign w_push   = iValid && oReady && !iFlush;
  assign w_head   = r_mem[r_rd_ptr];

  assign oWE      = r_we;
  assign oAddr    = r_addr;
  assign oDataW   = r_data_w;
  assign oRdValid = r_rd_valid;
  assign oRdData  = r_rd_data;
  assign oBusy    = (r_count != '0) || (r_state != S_IDLE) || r_rd_valid;

  // Next-state and control decode for the IDLE/WAIT/ISSUE sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue     = 1'b0;
    w_cnt_dec   = 1'b0;
    if (iFlush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (r_count != '0) begin
            w_pop       = 1'b1;
            w_state_nxt = S_WAIT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_WAIT: begin
          if (clkEn) begin
            if (r_cnt != '0) begin
              w_cnt_dec = 1'b1;
            end else begin
              w_issue     = 1'b1;
              w_state_nxt = S_ISSUE;
            end
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
        S_ISSUE: w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FIFO storage; contents need no reset since the pointers qualify them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {iRead, iDelay, iAddr, iData};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (iFlush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Working copy of the command in flight and its delay counter.
  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      r_cmd_read <= 1'b0;
      r_cmd_addr <= 5'd0;
      r_cmd_data <= 8'd0;
      r_cnt      <= '0;
    end else if (iFlush) begin
      r_cnt <= '0;
    end else if (w_pop) begin
      {r_cmd_read, r_cnt, r_cmd_addr, r_cmd_data} <= w_head;
    end else if (w_cnt_dec) begin
      r_cnt <= r_cnt - DELAY_W'(1);
    end
  end

  // Bus outputs are loaded on entry to ISSUE so they are registered for exactly that cycle;
  // a flush during ISSUE leaves the access already under way untouched.
  always_ff @(posedge clk or negedge iRstN) begin
    if (!iRstN) begin
      r_we       <= 1'b0;
      r_addr     <= 5'd0;
      r_data_w   <= 8'd0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= 8'd0;
    end else begin
      r_we <= w_issue && !r_cmd_read;
      if (w_issue) r_addr <= r_cmd_addr;
      if (w_issue && !r_cmd_read) r_data_w <= r_cmd_data;
      r_rd_valid <= (r_state == S_ISSUE) && r_cmd_read;
      if ((r_state == S_ISSUE) && r_cmd_read) r_rd_data <= iDataR;
    end
  end

endmodule
